// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM, and a
// single-entry output register with frame-error and overrun reporting.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  input  logic       data_ack,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic          rx_meta, rx_s;
  logic [CW-1:0] baud_cnt, baud_nx;
  logic [2:0]    bit_idx, idx_nx;
  logic [7:0]    shift_reg, shift_nx;
  logic          load_byte;
  logic          fe_nx, ov_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= serial_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
    end else begin
      state     <= state_nx;
      baud_cnt  <= baud_nx;
      bit_idx   <= idx_nx;
      shift_reg <= shift_nx;
    end
  end

  // The counter free-runs inside a bit and is cleared at every sample point,
  // so the first sample lands mid start bit and later ones one bit apart.
  always_comb begin
    state_nx  = state;
    baud_nx   = baud_cnt + 1'b1;
    idx_nx    = bit_idx;
    shift_nx  = shift_reg;
    load_byte = 1'b0;
    fe_nx     = 1'b0;
    ov_nx     = 1'b0;
    case (state)
      S_IDLE: begin
        baud_nx = '0;
        idx_nx  = 3'd0;
        if (!rx_s) state_nx = S_START;
      end
      S_START: begin
        if (baud_cnt == HALF_LAST) begin
          baud_nx = '0;
          idx_nx  = 3'd0;
          state_nx = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (baud_cnt == FULL_LAST) begin
          baud_nx           = '0;
          shift_nx[bit_idx] = rx_s;
          if (bit_idx == 3'd7) state_nx = S_STOP;
          else                 idx_nx   = bit_idx + 3'd1;
        end
      end
      S_STOP: begin
        if (baud_cnt == FULL_LAST) begin
          baud_nx = '0;
          if (rx_s) begin
            if (!data_valid || data_ack) load_byte = 1'b1;
            else                         ov_nx     = 1'b1;
            state_nx = S_IDLE;
          end else begin
            fe_nx    = 1'b1;
            state_nx = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        baud_nx = '0;
        if (rx_s) state_nx = S_IDLE;
      end
      default: begin
        baud_nx  = '0;
        state_nx = S_IDLE;
      end
    endcase
  end

  // Output handshake: data_valid means data_out holds a byte the consumer has
  // not yet taken; data_ack high in a cycle clears it at the next edge unless
  // a new good byte lands in that same cycle, which reloads and keeps it high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= fe_nx;
      overrun   <= ov_nx;
      if (load_byte) begin
        data_out   <= shift_reg;
        data_valid <= 1'b1;
      end else if (data_ack) begin
        data_valid <= 1'b0;
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are described by their bit timing and a
// cycle-indexed model predicts every output, plus literal spot checks.
module tb_uart_rx;

  localparam int CPB      = 16;
  localparam int STOP_OFS = CPB / 2 + 9 * CPB;   // stop sample relative to T0

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic       data_ack;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [2:0] state_dbg;

  logic ack_auto, ack_man, auto_ack;
  assign data_ack = ack_auto | ack_man;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .data_ack(data_ack),
    .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err),
    .overrun(overrun), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct { int lo; int hi; } win_t;
  typedef struct { int kind; logic [7:0] b; } ev_t;   // kind 1 good stop, 2 bad stop

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  win_t       win_q[$];
  ev_t        ev_map[int];
  logic [7:0] m_data;
  logic       m_valid, m_fe, m_ov;
  int         fe_cnt, ov_cnt, busy_cnt, rise_cyc, fall_cyc;
  logic       prev_valid = 1'b0;
  logic       prev_busy = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: advances at each edge using the data_ack of the cycle just ended.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_data = 8'h00; m_valid = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
      win_q.delete();
      ev_map.delete();
    end else begin
      logic good, bad, nov;
      good = 1'b0; bad = 1'b0; nov = 1'b0;
      if (ev_map.exists(cyc)) begin
        good = (ev_map[cyc].kind == 1);
        bad  = (ev_map[cyc].kind == 2);
      end
      if (good && (!m_valid || data_ack)) begin
        m_valid = 1'b1;
        m_data  = ev_map[cyc].b;
      end else begin
        if (good) nov = 1'b1;
        if (data_ack) m_valid = 1'b0;
      end
      if (ev_map.exists(cyc)) ev_map.delete(cyc);
      m_fe = bad;
      m_ov = nov;
    end
    cyc = cyc + 1;
  end

  // Compare every cycle on the falling edge.
  initial forever begin
    logic       e_busy, e_valid, e_fe, e_ov;
    logic [7:0] e_data;
    @(negedge clk);
    e_busy = 1'b0;
    foreach (win_q[i]) if (cyc >= win_q[i].lo && cyc <= win_q[i].hi) e_busy = 1'b1;
    if (rst) begin
      e_busy = 1'b0; e_valid = 1'b0; e_fe = 1'b0; e_ov = 1'b0; e_data = 8'h00;
    end else begin
      e_valid = m_valid; e_fe = m_fe; e_ov = m_ov; e_data = m_data;
    end
    chk("data_out", 32'(data_out), 32'(e_data));
    chk("data_valid", 32'(data_valid), 32'(e_valid));
    chk("frame_err", 32'(frame_err), 32'(e_fe));
    chk("overrun", 32'(overrun), 32'(e_ov));
    chk("busy", 32'(busy), 32'(e_busy));
    fe_cnt   += int'(frame_err);
    ov_cnt   += int'(overrun);
    busy_cnt += int'(busy);
    if (data_valid && !prev_valid) begin
      rise_cyc = cyc;
      got_q.push_back(data_out);
    end
    if (!busy && prev_busy) fall_cyc = cyc;
    prev_valid = data_valid;
    prev_busy  = busy;
  end

  initial begin
    ack_auto = 1'b0;
    forever begin
      @(posedge clk); #1;
      ack_auto = auto_ack && data_valid;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called just after an edge; serial_in first goes low in cycle c, so T0 = c+2.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len,
                            input int extra_low, input int ack_at, input int limit,
                            output int c);
    int t0, total;
    c  = cyc;
    t0 = c + 2;
    if (stop) begin
      win_q.push_back('{t0 + 1, t0 + STOP_OFS});
      ev_map[t0 + STOP_OFS] = '{1, b};
    end else begin
      win_q.push_back('{t0 + 1, c + 9 * CPB + stop_len + extra_low + 2});
      ev_map[t0 + STOP_OFS] = '{2, b};
    end
    total = 9 * CPB + stop_len + extra_low;
    if (limit > 0 && limit < total) total = limit;
    for (int i = 0; i < total; i++) begin
      if (i < CPB)                      serial_in = 1'b0;
      else if (i < 9 * CPB)             serial_in = b[i / CPB - 1];
      else if (i < 9 * CPB + stop_len)  serial_in = stop;
      else                              serial_in = 1'b0;
      ack_man = (i == ack_at);
      @(posedge clk); #1;
    end
    serial_in = 1'b1;
    ack_man   = 1'b0;
  endtask

  initial begin
    int c;
    rst = 1'b1; serial_in = 1'b1; ack_man = 1'b0; auto_ack = 1'b0;
    fe_cnt = 0; ov_cnt = 0; busy_cnt = 0; rise_cyc = -1; fall_cyc = -1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(5);
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_state", 32'(state_dbg), 32'h0);

    // 0xA5, good stop: byte visible and busy low at T0+153
    send_frame(8'hA5, 1'b1, CPB, 0, -1, 0, c);
    idle(5);
    chk("a5_rise_cyc", 32'(rise_cyc), 32'(c + 2 + 153));
    chk("a5_busy_fall", 32'(fall_cyc), 32'(c + 2 + 153));
    chk("a5_data", 32'(data_out), 32'hA5);
    chk("a5_flags", 32'(fe_cnt + ov_cnt), 32'd0);
    ack_man = 1'b1; idle(1); ack_man = 1'b0; idle(2);
    chk("a5_ack_clears", 32'(data_valid), 32'h0);

    // 4-cycle glitch: busy for 8 cycles, nothing else
    busy_cnt = 0;
    c = cyc;
    win_q.push_back('{c + 3, c + 10});
    serial_in = 1'b0; idle(4); serial_in = 1'b1; idle(20);
    chk("glitch_busy_cycles", 32'(busy_cnt), 32'd8);
    chk("glitch_flags", 32'(fe_cnt + int'(data_valid)), 32'd0);

    // 0x3C, bad stop, line low 40 more cycles: one frame_err
    send_frame(8'h3C, 1'b0, CPB, 40, -1, 0, c);
    idle(10);
    chk("break_fe_count", 32'(fe_cnt), 32'd1);
    chk("break_busy_fall", 32'(fall_cyc), 32'(c + 203));
    chk("break_valid", 32'(data_valid), 32'h0);

    // 0x11 then 0x22 unacknowledged: one overrun, 0x11 kept
    ov_cnt = 0;
    send_frame(8'h11, 1'b1, CPB, 0, -1, 0, c);
    send_frame(8'h22, 1'b1, CPB, 0, -1, 0, c);
    idle(5);
    chk("ovr_data", 32'(data_out), 32'h11);
    chk("ovr_count", 32'(ov_cnt), 32'd1);
    // ack coincident with the stop sample of 0x33: reload, no overrun
    send_frame(8'h33, 1'b1, CPB, 0, 2 + STOP_OFS, 0, c);
    idle(5);
    chk("coinc_data", 32'(data_out), 32'h33);
    chk("coinc_valid", 32'(data_valid), 32'h1);
    chk("coinc_ovr_count", 32'(ov_cnt), 32'd1);
    ack_man = 1'b1; idle(1); ack_man = 1'b0; idle(2);
    chk("ovr_ack_clears", 32'(data_valid), 32'h0);

    // reset during bit 3 of 0x5A, then 0xC3
    fe_cnt = 0; ov_cnt = 0;
    send_frame(8'h5A, 1'b1, CPB, 0, -1, 4 * CPB + 6, c);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_data_out", 32'(data_out), 32'h00);
    chk("midrst_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    idle(2);
    rst = 1'b0;
    idle(10);
    send_frame(8'hC3, 1'b1, CPB, 0, -1, 0, c);
    idle(5);
    chk("postrst_data", 32'(data_out), 32'hC3);
    chk("postrst_valid", 32'(data_valid), 32'h1);
    chk("postrst_flags", 32'(fe_cnt + ov_cnt), 32'd0);
    ack_man = 1'b1; idle(1); ack_man = 1'b0; idle(2);

    // back-to-back with no dead time, auto acknowledge
    got_q.delete();
    exp_q = '{8'h00, 8'hFF, 8'h81};
    auto_ack = 1'b1;
    send_frame(8'h00, 1'b1, 9, 0, -1, 0, c);
    send_frame(8'hFF, 1'b1, 9, 0, -1, 0, c);
    send_frame(8'h81, 1'b1, CPB, 0, -1, 0, c);
    idle(10);
    auto_ack = 1'b0;
    chk("b2b_count", 32'(got_q.size()), 32'd3);
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk("b2b_byte", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    chk("b2b_flags", 32'(fe_cnt + ov_cnt), 32'd0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
